msg_fifo_peek: RTL and testbench

- Parametrised successor to the CPU's fixed 4-entry, 2-bit message-type FIFO between prefetch and decoder.
- Generalises payload width and depth.
- Exposes the oldest PEEK entries in parallel, so the decoder can look ahead.
- Supports multi-entry pop (0..PEEK per cycle) and synchronous flush on branch/redirect.

---
 rtl/msg_fifo_peek.sv | 86 ++++++++
 tb/tb_msg_fifo_peek.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/msg_fifo_peek.sv
// Message-type FIFO with PEEK oldest entries exposed in parallel and 0..PEEK pops/cycle; optional MSG_FIFO_BYPASS_EN.
// Latency: push visible on peek next cycle (same cycle from empty with bypass); pops reflected next cycle.
// Backpressure: push_ready = count < DEPTH from registered state only; over-pop clamps and sets sticky underflow.
module msg_fifo_peek #(
    parameter int BITS  = 2,
    parameter int DEPTH = 4,
    parameter int PEEK  = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push_valid,
    input  logic [BITS-1:0]              push_data,
    output logic                         push_ready,
    output logic [PEEK*BITS-1:0]         peek_data,
    output logic [PEEK-1:0]              peek_valid,
    input  logic [$clog2(PEEK+1)-1:0]    pop_n,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [BITS-1:0] mem [DEPTH];
    logic [AW-1:0]   rd;
    logic [AW-1:0]   wr_slot;
    logic [CW-1:0]   pop_eff;
    logic [CW-1:0]   cnt_next;
    logic            bypass;
    logic            push_acc;
    logic            store;
    logic            uf_set;

    assign push_ready = (count < CW'(DEPTH));

`ifdef MSG_FIFO_BYPASS_EN
    assign bypass = push_valid && (count == '0) && !flush && !reset;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        push_acc = push_valid && push_ready && !flush && !reset;
        wr_slot  = rd + count[AW-1:0];
        // A bypassed entry counts as one available entry for the underflow check.
        uf_set   = 32'(pop_n) > (32'(count) + 32'(bypass));
        pop_eff  = (32'(pop_n) > 32'(count)) ? count : CW'(pop_n);
        // A bypassed entry that is popped in the same cycle is never stored.
        store    = push_acc && !(bypass && (pop_n != '0));
        cnt_next = count - pop_eff + CW'(store);
    end

    always_comb begin
        peek_valid = '0;
        peek_data  = '0;
        for (int i = 0; i < PEEK; i++) begin
            if (i < int'(count)) begin
                peek_valid[i]              = 1'b1;
                peek_data[i*BITS +: BITS]  = mem[rd + AW'(i)];
            end
        end
        if (bypass) begin
            peek_valid[0]          = 1'b1;
            peek_data[BITS-1:0]    = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd        <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            rd    <= rd + pop_eff[AW-1:0];
            count <= cnt_next;
            if (uf_set)
                underflow <= 1'b1;
        end
    end

    // Storage needs no reset; unused slots are masked on peek.
    always_ff @(posedge clk) begin
        if (store)
            mem[wr_slot] <= push_data;
    end
endmodule

// File: tb/tb_msg_fifo_peek.sv
// Directed-vector bench for msg_fifo_peek (BITS=2, DEPTH=4, PEEK=3), both MSG_FIFO_BYPASS_EN builds.
module tb_msg_fifo_peek;
    logic       clk = 1'b0;
    logic       reset, flush, push_valid, push_ready, underflow;
    logic [1:0] push_data, pop_n;
    logic [5:0] peek_data;
    logic [2:0] peek_valid, count;
    int         vec_cnt = 0;
    int         err_cnt = 0;

    msg_fifo_peek #(.BITS(2), .DEPTH(4), .PEEK(3)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .peek_data(peek_data), .peek_valid(peek_valid), .pop_n(pop_n),
        .count(count), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] d);
        push_valid = 1'b1;
        push_data  = d;
        step();
        push_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; push_valid = 1'b0; push_data = '0; pop_n = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_pvalid", 32'(peek_valid), 0);
        chk("rst_pdata", 32'(peek_data), 0);
        chk("rst_uflow", 32'(underflow), 0);
        chk("rst_ready", 32'(push_ready), 1);

        // push 2,1,3
        push(2'd2); push(2'd1); push(2'd3);
        chk("p3_count", 32'(count), 3);
        chk("p3_pvalid", 32'(peek_valid), 32'h7);
        chk("p3_pdata", 32'(peek_data), 32'h36);

        // flush beats simultaneous push and pop
        flush = 1'b1; push_valid = 1'b1; push_data = 2'd1; pop_n = 2'd1;
        step();
        flush = 1'b0; push_valid = 1'b0; pop_n = 2'd0;
        chk("fl_count", 32'(count), 0);
        chk("fl_pvalid", 32'(peek_valid), 0);
        step();
        chk("fl_count2", 32'(count), 0);

        // fill to full, hold push while full
        push(2'd0); push(2'd1); push(2'd2); push(2'd3);
        chk("full_count", 32'(count), 4);
        chk("full_ready", 32'(push_ready), 0);
        chk("full_pdata", 32'(peek_data), 32'h24);
        push_valid = 1'b1; push_data = 2'd2;
        step();
        chk("full_hold", 32'(count), 4);
        pop_n = 2'd2;
        #1;
        chk("full_ready_pop", 32'(push_ready), 0);
        step();
        pop_n = 2'd0;
        chk("pop2_count", 32'(count), 2);
        chk("pop2_pvalid", 32'(peek_valid), 32'h3);
        chk("pop2_pdata", 32'(peek_data), 32'h0E);
        chk("pop2_ready", 32'(push_ready), 1);
        step();
        push_valid = 1'b0;
        chk("rp_count", 32'(count), 3);
        chk("rp_pdata", 32'(peek_data), 32'h2E);

        // drain exactly (no underflow)
        pop_n = 2'd3;
        step();
        pop_n = 2'd0;
        chk("drain_count", 32'(count), 0);
        chk("drain_uflow", 32'(underflow), 0);

        // wrap-around: push one / pop one
        push(2'd0);
        for (int k = 1; k <= 10; k++) begin
            push_valid = 1'b1; push_data = 2'(k % 4); pop_n = 2'd1;
            step();
            chk("wrap_count", 32'(count), 1);
            chk("wrap_e0", 32'(peek_data[1:0]), 32'(k % 4));
        end
        push_valid = 1'b0; pop_n = 2'd0;
        chk("wrap_pvalid", 32'(peek_valid), 1);

        // underflow: count=1, pop 3
        pop_n = 2'd3;
        step();
        pop_n = 2'd0;
        chk("uf_count", 32'(count), 0);
        chk("uf_set", 32'(underflow), 1);
        step();
        chk("uf_sticky", 32'(underflow), 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("uf_clr", 32'(underflow), 0);
        chk("uf_clr_count", 32'(count), 0);
        chk("uf_clr_pvalid", 32'(peek_valid), 0);

        // reset mid-operation drops contents and the in-flight push
        push(2'd1); push(2'd2);
        reset = 1'b1; push_valid = 1'b1; push_data = 2'd3;
        step();
        reset = 1'b0; push_valid = 1'b0;
        chk("rmid_count", 32'(count), 0);
        chk("rmid_pvalid", 32'(peek_valid), 0);

        // push into empty FIFO while popping one
        push_valid = 1'b1; push_data = 2'd3; pop_n = 2'd1;
        #1;
`ifdef MSG_FIFO_BYPASS_EN
        chk("byp_pvalid", 32'(peek_valid), 1);
        chk("byp_pdata0", 32'(peek_data[1:0]), 3);
`else
        chk("byp_pvalid", 32'(peek_valid), 0);
`endif
        step();
        push_valid = 1'b0; pop_n = 2'd0;
`ifdef MSG_FIFO_BYPASS_EN
        chk("byp_count", 32'(count), 0);
        chk("byp_uflow", 32'(underflow), 0);
`else
        chk("byp_count", 32'(count), 1);
        chk("byp_uflow", 32'(underflow), 1);
        chk("byp_e0", 32'(peek_data[1:0]), 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
